// File: rtl/magnetron_sequencer.sv
// Cook-cycle controller: holds cook time and power level, counts the time
// down in seconds, drives the magnetron with a power-level duty cycle over a
// 10-second window and enforces the door interlock.
module magnetron_sequencer #(
  parameter int TICKS_PER_SEC = 1000,
  parameter int TIME_W        = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic              door_closed,
  input  logic              time_load,
  input  logic [TIME_W-1:0] time_in,
  input  logic [3:0]        power_in,
  output logic              magnetron_on,
  output logic [TIME_W-1:0] time_left,
  output logic [1:0]        state,
  output logic              done
);

  localparam int PS_W = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PS_W-1:0] PS_MAX = PS_W'(TICKS_PER_SEC - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COOK  = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [TIME_W-1:0] time_left_q, time_left_d;
  logic [3:0]        power_q, power_d;
  logic [PS_W-1:0]   prescaler_q, prescaler_d;
  logic [3:0]        duty_cnt_q, duty_cnt_d;
  logic              mag_en_q, mag_en_d;
  logic              done_q, done_d;
  logic              sec_tick;
  logic [3:0]        power_clamped;

  // Power levels outside 1..10 fall back to full power
  assign power_clamped = ((power_in == 4'd0) || (power_in > 4'd10)) ? 4'd10 : power_in;
  assign sec_tick      = (prescaler_q == PS_MAX);

  // Next-state logic; stop always wins over start, and any exit from COOK
  // freezes the counters so only uninterrupted cook cycles consume time
  always_comb begin
    state_d     = state_q;
    time_left_d = time_left_q;
    power_d     = power_q;
    prescaler_d = prescaler_q;
    duty_cnt_d  = duty_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (time_load) begin
          time_left_d = time_in;
          power_d     = power_clamped;
        end
        if (start && !stop && door_closed && (time_left_q != '0)) begin
          state_d     = COOK;
          prescaler_d = '0;
          duty_cnt_d  = 4'd0;
        end
      end
      COOK: begin
        if (!door_closed || stop) begin
          state_d = PAUSE;
        end else if (sec_tick) begin
          prescaler_d = '0;
          duty_cnt_d  = (duty_cnt_q == 4'd9) ? 4'd0 : duty_cnt_q + 4'd1;
          if (time_left_q <= TIME_W'(1)) begin
            time_left_d = '0;
            state_d     = DONE;
          end else begin
            time_left_d = time_left_q - TIME_W'(1);
          end
        end else begin
          prescaler_d = prescaler_q + PS_W'(1);
        end
      end
      PAUSE: begin
        if (stop) begin
          state_d     = IDLE;
          time_left_d = '0;
        end else if (start && door_closed) begin
          state_d = COOK;
        end
      end
      DONE: begin
        if (stop || !door_closed) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    mag_en_d = (state_d == COOK) && (duty_cnt_d < power_d);
    done_d   = (state_d == DONE);
  end

  // State and registered outputs; reset forces everything safe at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      time_left_q <= '0;
      power_q     <= 4'd10;
      prescaler_q <= '0;
      duty_cnt_q  <= 4'd0;
      mag_en_q    <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      time_left_q <= time_left_d;
      power_q     <= power_d;
      prescaler_q <= prescaler_d;
      duty_cnt_q  <= duty_cnt_d;
      mag_en_q    <= mag_en_d;
      done_q      <= done_d;
    end
  end

  // Door gate stays combinational so an opening door cuts power immediately
  assign magnetron_on = mag_en_q && door_closed;
  assign time_left    = time_left_q;
  assign state        = state_q;
  assign done         = done_q;

endmodule

// File: tb/tb_magnetron_sequencer.sv
// Directed testbench for magnetron_sequencer with TICKS_PER_SEC=4.
module tb_magnetron_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        stop;
  logic        door_closed;
  logic        time_load;
  logic [11:0] time_in;
  logic [3:0]  power_in;
  logic        magnetron_on;
  logic [11:0] time_left;
  logic [1:0]  state;
  logic        done;

  int testCnt;
  int failCnt;
  int onCnt;

  magnetron_sequencer #(
    .TICKS_PER_SEC(4),
    .TIME_W(12)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .stop(stop),
    .door_closed(door_closed),
    .time_load(time_load),
    .time_in(time_in),
    .power_in(power_in),
    .magnetron_on(magnetron_on),
    .time_left(time_left),
    .state(state),
    .done(done)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle just after the rising edge
  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testCnt++;
    assert (obs === exp) else begin
      failCnt++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [11:0] t, input logic [3:0] p);
    time_load = 1'b1;
    time_in   = t;
    power_in  = p;
    step();
    time_load = 1'b0;
  endtask

  task automatic pulseStart();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic pulseStop();
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  initial begin
    testCnt     = 0;
    failCnt     = 0;
    rst_n       = 1'b0;
    start       = 1'b0;
    stop        = 1'b0;
    door_closed = 1'b1;
    time_load   = 1'b0;
    time_in     = '0;
    power_in    = 4'd10;

    // Reset state
    #12;
    checkOutput("rst_state", state, 0);
    checkOutput("rst_time", time_left, 0);
    checkOutput("rst_mag", magnetron_on, 0);
    checkOutput("rst_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Basic cook: 3 s at power 10
    applyStimulus(12'd3, 4'd10);
    checkOutput("load_time", time_left, 3);
    checkOutput("load_state", state, 0);
    pulseStart();
    checkOutput("cook_entry_state", state, 1);
    checkOutput("cook_entry_mag", magnetron_on, 1);
    onCnt = 0;
    for (int c = 0; c < 12; c++) begin
      if (magnetron_on) onCnt++;
      if (c == 3) checkOutput("basic_t_c3", time_left, 3);
      if (c == 4) checkOutput("basic_t_c4", time_left, 2);
      if (c == 8) checkOutput("basic_t_c8", time_left, 1);
      step();
    end
    checkOutput("basic_on_cycles", onCnt, 12);
    checkOutput("basic_done_state", state, 3);
    checkOutput("basic_done", done, 1);
    checkOutput("basic_done_time", time_left, 0);
    checkOutput("basic_done_mag", magnetron_on, 0);
    pulseStop();
    checkOutput("basic_stop_state", state, 0);
    checkOutput("basic_stop_done", done, 0);

    // Start with time_left==0 is ignored
    pulseStart();
    checkOutput("zero_time_start", state, 0);

    // Duty cycle: 20 s at power 3
    applyStimulus(12'd20, 4'd3);
    pulseStart();
    for (int c = 0; c < 52; c++) begin
      checkOutput($sformatf("duty_c%0d", c), magnetron_on, ((c < 12) || (c >= 40)) ? 1 : 0);
      if (c == 40) checkOutput("duty_t_c40", time_left, 10);
      step();
    end
    checkOutput("duty_t_end", time_left, 7);
    pulseStop();
    checkOutput("cook_stop_pause", state, 2);
    checkOutput("pause_time_kept", time_left, 7);
    pulseStop();
    checkOutput("pause_stop_idle", state, 0);
    checkOutput("pause_stop_time", time_left, 0);

    // Door interlock: 6 s at power 10, door opens at time_left=5
    applyStimulus(12'd6, 4'd10);
    pulseStart();
    onCnt = 0;
    for (int c = 0; c < 5; c++) begin
      if (magnetron_on) onCnt++;
      step();
    end
    checkOutput("door_pre_time", time_left, 5);
    door_closed = 1'b0;
    #1;
    checkOutput("door_mag_comb", magnetron_on, 0);
    checkOutput("door_state_same", state, 1);
    step();
    checkOutput("door_pause_state", state, 2);
    checkOutput("door_pause_time", time_left, 5);
    pulseStart();
    checkOutput("door_open_start_ignored", state, 2);
    door_closed = 1'b1;
    step();
    checkOutput("door_closed_still_pause", state, 2);
    checkOutput("door_closed_mag_off", magnetron_on, 0);
    pulseStart();
    checkOutput("resume_state", state, 1);
    checkOutput("resume_time", time_left, 5);
    for (int i = 0; (i < 100) && (state !== 2'd3); i++) begin
      if (magnetron_on) onCnt++;
      step();
    end
    checkOutput("door_done_state", state, 3);
    checkOutput("door_total_on", onCnt, 24);
    door_closed = 1'b0;
    step();
    checkOutput("done_door_idle", state, 0);
    door_closed = 1'b1;

    // time_load during COOK is ignored
    applyStimulus(12'd5, 4'd10);
    pulseStart();
    applyStimulus(12'd99, 4'd10);
    checkOutput("load_in_cook", time_left, 5);
    pulseStop();
    checkOutput("pause_again", state, 2);
    start = 1'b1;
    stop  = 1'b1;
    step();
    start = 1'b0;
    stop  = 1'b0;
    checkOutput("pause_start_stop", state, 0);
    checkOutput("pause_start_stop_time", time_left, 0);

    // Simultaneous start and stop in IDLE
    applyStimulus(12'd5, 4'd10);
    start = 1'b1;
    stop  = 1'b1;
    step();
    start = 1'b0;
    stop  = 1'b0;
    checkOutput("idle_start_stop", state, 0);

    // Out-of-range power levels give continuous enable
    for (int k = 0; k < 2; k++) begin
      applyStimulus(12'd20, (k == 0) ? 4'd0 : 4'd15);
      pulseStart();
      onCnt = 0;
      for (int c = 0; c < 40; c++) begin
        if (magnetron_on) onCnt++;
        step();
      end
      checkOutput($sformatf("power_clamp_%0d", k), onCnt, 40);
      pulseStop();
      pulseStop();
    end

    // Start with door open is ignored in IDLE
    applyStimulus(12'd5, 4'd10);
    door_closed = 1'b0;
    pulseStart();
    checkOutput("idle_door_open_start", state, 0);
    door_closed = 1'b1;

    // Asynchronous reset mid-cook
    pulseStart();
    step(2);
    checkOutput("pre_reset_cook", state, 1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_mag", magnetron_on, 0);
    checkOutput("arst_time", time_left, 0);
    checkOutput("arst_state", state, 0);
    checkOutput("arst_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    pulseStart();
    checkOutput("post_reset_start", state, 0);

    $display("[TB] %0d tests run, %0d failed", testCnt, failCnt);
    $finish;
  end

endmodule

// File: doc/magnetron_sequencer.md
# magnetron_sequencer

Cook-cycle controller for the microwave magnetron path. It holds the programmed cook time and power level and counts the time down in seconds. It drives the magnetron enable with a power-level duty cycle over a 10-second window, and enforces the door interlock. It sits between the front-panel input decoding and the magnetron drive, and replaces the bare set/reset latch as the owner of magnetron on/off.

## Interface
- TICKS_PER_SEC, default 1000: clock cycles per one-second tick; must be at least 2.
- TIME_W, default 12: width of the cook-time counter in seconds.
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  start/resume request, sampled each cycle.
- stop  in  1  pause/cancel request, sampled each cycle.
- door_closed  in  1  interlock; 1 = door closed.
- time_load  in  1  load time_in/power_in, honoured only in IDLE.
- time_in  in  TIME_W  cook time in seconds.
- power_in  in  4  power level; 1..10 used as is, 0 or >10 treated as 10.
- magnetron_on  out  1  magnetron enable.
- time_left  out  TIME_W  remaining seconds.
- state  out  2  IDLE=0, COOK=1, PAUSE=2, DONE=3.
- done  out  1  high while state==DONE.

## Operation
- Reset: state=IDLE, time_left=0, power=10, prescaler=0, duty_cnt=0, magnetron_on=0, done=0.
- IDLE:
  - time_load sets time_left=time_in and power=clamped power_in.
  - start && door_closed && time_left!=0 moves to COOK, clearing prescaler and duty_cnt.
  - start with time_left==0 or door open is ignored.
- COOK:
  - prescaler counts 0..TICKS_PER_SEC-1 and wraps.
  - On each wrap (sec_tick): time_left decrements and duty_cnt advances 0..9, wrapping 9 to 0.
  - Exit priority, highest first:
    - !door_closed goes to PAUSE.
    - stop goes to PAUSE.
    - sec_tick with time_left==1 goes to DONE, and time_left becomes 0.
- PAUSE:
  - prescaler, duty_cnt and time_left are frozen.
  - start && door_closed && !stop resumes COOK, continuing from the frozen values.
  - stop goes to IDLE with time_left=0.
  - start while the door is open is ignored.
- DONE: done=1. stop or !door_closed goes to IDLE. start is ignored.
- time_load outside IDLE is ignored.
- Simultaneous start and stop: stop wins in every state.
- magnetron_on = mag_en_q && door_closed.
  - mag_en_q is a register, 1 only in COOK with duty_cnt < power.
  - The door gate is combinational, so the magnetron drops in the same cycle the door opens, with no register delay.
- power=10 gives a continuous enable; power=k gives k seconds on then 10-k seconds off per window.

## Timing
- Control inputs are sampled at edge N; the new state is visible after edge N.
- start in IDLE at edge N: state=COOK and magnetron_on=1 from edge N (duty_cnt=0 < power≥1).
- First decrement comes TICKS_PER_SEC cycles after COOK entry, then every TICKS_PER_SEC COOK cycles.
- Cooking T seconds uninterrupted takes exactly T×TICKS_PER_SEC cycles from COOK entry to DONE entry. magnetron_on is 0 from DONE entry.
- Door opening mid-COOK:
  - magnetron_on=0 combinationally in the same cycle.
  - state=PAUSE after the next edge.
  - A sec_tick coinciding with that edge is not applied.
- Paused time does not count. Total COOK cycles is always T×TICKS_PER_SEC regardless of pauses.
- rst_n assertion in any state immediately forces the reset values, including magnetron_on=0.

## Test plan
All scenarios use TICKS_PER_SEC=4 and TIME_W=12.

- Basic cook: load time 3, power 10, door closed, start. Required: magnetron_on=1 for exactly 12 cycles, time_left 3→2→1→0 at 4-cycle intervals, then state=DONE, done=1. Then stop: state=IDLE.
- Duty cycle: load time 20, power 3, start. Required: magnetron_on high for cycles 0–11, low 12–39, high 40–51 relative to COOK entry; time_left=10 at cycle 40.
- Door interlock: during COOK at time_left=5, drop door_closed for 1 cycle. Required: magnetron_on=0 that same cycle, state=PAUSE, time_left stays 5. Close the door and pulse start: COOK resumes, and total COOK cycles still equal 4×loaded time.
- Cancel and ignore: stop in PAUSE gives IDLE with time_left=0. start with time_left=0 stays IDLE. time_load during COOK leaves time_left unchanged.
- Simultaneous and edge events:
  - start+stop together in IDLE: stays IDLE.
  - start+stop together in PAUSE: goes to IDLE.
  - power_in=0 and power_in=15 both give a continuous enable.
  - start with the door open is ignored.
- Reset mid-cook: assert rst_n=0 asynchronously between edges in COOK. Required: magnetron_on, time_left, state and done all 0 immediately. After release, start without time_load stays IDLE.
